// File: rtl/dmx_pkg.sv
// Shared DMX write-path types and constants for the port-B write arbiter.
package dmx_pkg;

    localparam int unsigned DMX_PORTS  = 4;
    localparam int unsigned DMX_CH_MAX = 512;
    localparam int unsigned DMX_ADDR_W = 10;
    localparam int unsigned DMX_DATA_W = 8;

    typedef enum logic [0:0] {
        StArb,
        StClear
    } dmx_state_e;

    typedef struct packed {
        logic [1:0]            port;
        logic [DMX_ADDR_W-1:0] addr;
        logic [DMX_DATA_W-1:0] data;
    } dmx_wr_req_t;

    function automatic logic [DMX_PORTS-1:0] port_onehot(input logic [1:0] port);
        return 4'b0001 << port;
    endfunction

endpackage

// File: rtl/dmx_wr_arbiter_if.sv
// Requester-side write handshake bundle: packed per-requester valid/ready and payload.
interface dmx_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 10
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [2*NUM_REQ-1:0]      req_port;
    logic [ADDR_W*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0]      req_data;

    modport master (
        output req_valid,
        output req_port,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_port,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after the pointer wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IdxW    = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IdxW-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IdxW-1:0]    idx_o
);

    logic            found;
    logic [IdxW-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = IdxW'((32'(ptr_i) + k) % NUM_REQ);
            if (en_i && !found && valid_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/dmx_wr_arbiter.sv
// EBR port-B write arbiter for the four DMX outputs: round-robin requesters plus a
// zero-fill clear sweeper that owns the bus while it runs.
module dmx_wr_arbiter
    import dmx_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned CH_MAX  = DMX_CH_MAX,
    parameter int unsigned ADDR_W  = DMX_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmx_wr_arbiter_if.slave        req_if,
    input  logic                   clr_start,
    input  logic [DMX_PORTS-1:0]   clr_mask,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic [ADDR_W-1:0]      ebr_addr,
    output logic [DMX_DATA_W-1:0]  ebr_data,
    output logic [DMX_PORTS-1:0]   ebr_wr,
    output logic                   err_drop
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    dmx_state_e             state_q, state_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic [DMX_PORTS-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DMX_DATA_W-1:0]  data_q, data_d;
    logic [DMX_PORTS-1:0]   wr_q, wr_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic                   clr_go;
    logic                   arb_en;
    logic [NUM_REQ-1:0]     gnt;
    logic [IdxW-1:0]        gnt_idx;
    logic [1:0]             sel_port;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DMX_DATA_W-1:0]  sel_data;

    // A real clear request steals the cycle from the requesters.
    assign clr_go = clr_start && (clr_mask != '0);
    assign arb_en = (state_q == StArb) && !clr_go;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_rr (
        .valid_i (req_if.req_valid),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx)
    );

    assign req_if.req_ready = gnt;

    always_comb begin
        sel_port = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_port = req_if.req_port[2*i +: 2];
                sel_addr = req_if.req_addr[ADDR_W*i +: ADDR_W];
                sel_data = req_if.req_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StArb: begin
                if (clr_go) begin
                    state_d = StClear;
                    mask_d  = clr_mask;
                    cnt_d   = '0;
                    wr_d    = clr_mask;
                    addr_d  = '0;
                    data_d  = '0;
                    busy_d  = 1'b1;
                end else if (|gnt) begin
                    ptr_d  = (gnt_idx == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    addr_d = sel_addr;
                    data_d = sel_data;
                    if (32'(sel_addr) < CH_MAX) begin
                        wr_d = port_onehot(sel_port);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StClear: begin
                // cnt_q tracks the address currently on the bus.
                if (cnt_q == ADDR_W'(CH_MAX - 1)) begin
                    state_d = StArb;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    wr_d   = mask_q;
                    addr_d = cnt_q + 1'b1;
                    data_d = '0;
                    busy_d = 1'b1;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StArb;
            ptr_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ebr_addr = addr_q;
    assign ebr_data = data_q;
    assign ebr_wr   = wr_q;
    assign clr_busy = busy_q;
    assign clr_done = done_q;
    assign err_drop = err_q;

endmodule

// File: tb/tb_dmx_wr_arbiter.sv
// Bench for dmx_wr_arbiter: behavioural model feeds an expected-output queue checked each cycle,
// plus directed scenarios for grant order, drops, clear sweeps and reset.
module tb_dmx_wr_arbiter;

    localparam int N = 3;
    localparam int CHM = 512;

    logic       clk;
    logic       rst_n;
    logic       clr_start;
    logic [3:0] clr_mask;
    logic       clr_busy;
    logic       clr_done;
    logic [9:0] ebr_addr;
    logic [7:0] ebr_data;
    logic [3:0] ebr_wr;
    logic       err_drop;

    dmx_wr_arbiter_if #(.NUM_REQ(N), .ADDR_W(10)) bus ();

    dmx_wr_arbiter #(
        .NUM_REQ (N),
        .CH_MAX  (CHM),
        .ADDR_W  (10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_if    (bus),
        .clr_start (clr_start),
        .clr_mask  (clr_mask),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ebr_addr  (ebr_addr),
        .ebr_data  (ebr_data),
        .ebr_wr    (ebr_wr),
        .err_drop  (err_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] wr;
        logic [9:0] addr;
        logic [7:0] data;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   glog[$];

    // Reference model state
    bit         m_clear;
    int         m_ptr;
    int         m_addr;
    logic [3:0] m_mask;
    exp_t       m_e;
    exp_t       m_nx;
    logic [N-1:0] m_ready;
    int         m_g;
    logic [1:0] m_port;
    logic [9:0] m_raddr;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_clear = 1'b0;
            m_ptr   = 0;
            m_addr  = 0;
            m_mask  = '0;
        end else begin
            m_e = '0;
            if (exp_q.size() > 0) m_e = exp_q.pop_front();
            check_eq("ebr_wr", ebr_wr, m_e.wr);
            if (m_e.wr != 0) begin
                check_eq("ebr_addr", ebr_addr, m_e.addr);
                check_eq("ebr_data", ebr_data, m_e.data);
            end
            check_eq("clr_busy", clr_busy, m_e.busy);
            check_eq("clr_done", clr_done, m_e.done);
            check_eq("err_drop", err_drop, m_e.err);

            m_ready = '0;
            m_g     = -1;
            m_nx    = '0;
            if (!m_clear && !(clr_start && clr_mask != 0)) begin
                for (int k = 0; k < N; k++) begin
                    if (m_g < 0 && bus.req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
                end
                if (m_g >= 0) m_ready[m_g] = 1'b1;
            end
            check_eq("req_ready", bus.req_ready, m_ready);

            if (m_clear) begin
                if (m_addr == CHM - 1) begin
                    m_clear    = 1'b0;
                    m_nx.done  = 1'b1;
                end else begin
                    m_addr    = m_addr + 1;
                    m_nx.wr   = m_mask;
                    m_nx.addr = 10'(m_addr);
                    m_nx.busy = 1'b1;
                end
            end else if (clr_start && clr_mask != 0) begin
                m_clear   = 1'b1;
                m_mask    = clr_mask;
                m_addr    = 0;
                m_nx.wr   = clr_mask;
                m_nx.busy = 1'b1;
            end else if (m_g >= 0) begin
                glog.push_back(m_g);
                m_ptr   = (m_g + 1) % N;
                m_port  = bus.req_port[2*m_g +: 2];
                m_raddr = bus.req_addr[10*m_g +: 10];
                if (int'(m_raddr) < CHM) begin
                    m_nx.wr   = 4'b0001 << m_port;
                    m_nx.addr = m_raddr;
                    m_nx.data = bus.req_data[8*m_g +: 8];
                end else begin
                    m_nx.err = 1'b1;
                end
            end
            exp_q.push_back(m_nx);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_wr"}, ebr_wr, 4'b0);
        check_eq({tag, "_addr"}, ebr_addr, 10'd0);
        check_eq({tag, "_data"}, ebr_data, 8'd0);
        check_eq({tag, "_busy"}, clr_busy, 1'b0);
        check_eq({tag, "_done"}, clr_done, 1'b0);
        check_eq({tag, "_err"}, err_drop, 1'b0);
        check_eq({tag, "_ready"}, bus.req_ready, 3'b0);
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        clr_start     = 1'b0;
        clr_mask      = '0;
        tick();
        tick();
        check_idle_outputs("rst");
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [1:0] port, input logic [9:0] addr,
                           input logic [7:0] data);
        bus.req_port[2*i +: 2]  = port;
        bus.req_addr[10*i +: 10] = addr;
        bus.req_data[8*i +: 8]  = data;
        bus.req_valid[i]        = 1'b1;
    endtask

    // Holds the request until its handshake completes, then drops valid.
    task automatic send(input int i, input logic [1:0] port, input logic [9:0] addr,
                        input logic [7:0] data);
        int n;
        set_req(i, port, addr, data);
        #1;
        n = 0;
        while (!bus.req_ready[i] && n < 20) begin
            tick();
            n++;
        end
        check_eq("send_timeout", 32'(n == 20), 32'd0);
        tick();
        bus.req_valid[i] = 1'b0;
    endtask

    int n;
    int n_busy;

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_port  = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        clr_start     = 1'b0;
        clr_mask      = '0;
        do_reset();

        // Single write
        send(0, 2'd2, 10'h00A, 8'h7F);
        check_eq("t1_wr", ebr_wr, 4'b0100);
        check_eq("t1_addr", ebr_addr, 10'd10);
        check_eq("t1_data", ebr_data, 8'h7F);
        tick();
        check_eq("t1_wr_once", ebr_wr, 4'b0000);

        // Fairness from reset
        do_reset();
        glog.delete();
        for (int i = 0; i < N; i++) set_req(i, 2'(i), 10'(16 + i), 8'(8'hA0 + i));
        n = 0;
        while (glog.size() < 9 && n < 50) begin
            tick();
            n++;
        end
        bus.req_valid = '0;
        check_eq("fair_count", 32'(glog.size() >= 9), 32'd1);
        for (int k = 0; k < 9 && k < glog.size(); k++) check_eq("fair_order", glog[k], k % 3);
        tick();

        // Out-of-range then last valid slot
        send(1, 2'd1, 10'd512, 8'h55);
        check_eq("oor_err", err_drop, 1'b1);
        check_eq("oor_wr", ebr_wr, 4'b0000);
        tick();
        check_eq("oor_err_once", err_drop, 1'b0);
        send(1, 2'd3, 10'd511, 8'h33);
        check_eq("max_wr", ebr_wr, 4'b1000);
        check_eq("max_addr", ebr_addr, 10'd511);
        check_eq("max_err", err_drop, 1'b0);

        // Clear sweep with req0 pending and a redundant start mid-sweep
        tick();
        set_req(0, 2'd0, 10'd3, 8'h11);
        clr_start = 1'b1;
        clr_mask  = 4'b1010;
        #1;
        check_eq("clr_prio_ready", bus.req_ready, 3'b000);
        tick();
        clr_start = 1'b0;
        n_busy = 0;
        n = 0;
        while (!clr_done && n < 600) begin
            if (clr_busy) n_busy++;
            if (n == 100) begin
                clr_start = 1'b1;
                clr_mask  = 4'b0001;
            end else begin
                clr_start = 1'b0;
            end
            tick();
            n++;
        end
        clr_start = 1'b0;
        check_eq("clr_len", n_busy, CHM);
        check_eq("clr_done_seen", clr_done, 1'b1);
        check_eq("clr_resume_ready", bus.req_ready, 3'b001);
        tick();
        bus.req_valid[0] = 1'b0;
        check_eq("clr_done_once", clr_done, 1'b0);
        check_eq("clr_busy_end", clr_busy, 1'b0);

        // Zero-mask clear is ignored and arbitration proceeds
        tick();
        set_req(1, 2'd0, 10'd7, 8'h77);
        clr_start = 1'b1;
        clr_mask  = 4'b0000;
        #1;
        check_eq("mask0_ready", bus.req_ready, 3'b010);
        tick();
        clr_start        = 1'b0;
        bus.req_valid[1] = 1'b0;
        check_eq("mask0_busy", clr_busy, 1'b0);
        tick();
        check_eq("mask0_done", clr_done, 1'b0);

        // Reset in the middle of a sweep
        clr_start = 1'b1;
        clr_mask  = 4'b1111;
        tick();
        clr_start = 1'b0;
        n = 0;
        while (ebr_addr != 10'd200 && n < 300) begin
            tick();
            n++;
        end
        check_eq("midclr_reached", ebr_addr, 10'd200);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        tick();
        rst_n = 1'b1;
        set_req(2, 2'd3, 10'd5, 8'hAA);
        #1;
        check_eq("postrst_ready", bus.req_ready, 3'b100);
        tick();
        bus.req_valid[2] = 1'b0;
        check_eq("postrst_wr", ebr_wr, 4'b1000);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
